// File: rtl/alu_pkg.sv
// Shared encodings for the ALU control sequencer: op codes, FSM states and
// the default operand width / iteration counter width.
package alu_pkg;

    localparam int N_DEF     = 8;
    localparam int CNT_W_DEF = 3;

    typedef enum logic [1:0] {
        OP_ADD  = 2'b00,
        OP_SUB  = 2'b01,
        OP_MUL  = 2'b10,
        OP_RSVD = 2'b11
    } op_e;

    typedef enum logic [3:0] {
        IDLE,
        INIT,
        ADDX,
        LOADY,
        OP,
        LOADM,
        TEST,
        SHIFT,
        OUT_A,
        OUT_Q,
        DONE
    } state_e;

endpackage

// File: rtl/alu_ctrl.sv
// Control sequencer for the N-bit ALU datapath. Issues one-cycle strobes
// c0..c7 to the A/Q/M registers and the adder for ADD, SUB (6 cycles) and
// Booth radix-2 signed MUL (2N+5 cycles). Strobes are decoded from the state
// register; only the TEST state also looks at the Booth bits {q0,q_m1}.
// Optional feature: define ALU_CTRL_OVF_EN to compute the signed overflow of
// the last ADD/SUB on ovf; without it ovf is tied to 0.
module alu_ctrl
    import alu_pkg::*;
#(
    parameter int N     = N_DEF,
    parameter int CNT_W = CNT_W_DEF
) (
    input  logic             clk,
    input  logic             rst_b,
    input  logic             start,
    input  logic [1:0]       op,
    input  logic             q0,
    input  logic             q_m1,
    input  logic             a_msb,
    input  logic             m_msb,
    input  logic             sum_msb,
    output logic             c0,
    output logic             c1,
    output logic             c2,
    output logic             c3,
    output logic             c4,
    output logic             c5,
    output logic             c6,
    output logic             c7,
    output logic             busy,
    output logic             done,
    output logic             ovf,
    output logic [CNT_W-1:0] cnt
);

    if ((2 ** CNT_W) < N) begin : g_cnt_w_check
        $error("alu_ctrl: CNT_W too small to count N iterations");
    end

    localparam logic [CNT_W-1:0] LAST_ITER = CNT_W'(N - 1);

    state_e           state_q, state_d;
    op_e              op_q, op_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;

    // State, latched op and iteration counter registers
    always_ff @(posedge clk or negedge rst_b) begin
        if (!rst_b) begin
            state_q <= IDLE;
            op_q    <= OP_ADD;
            cnt_q   <= '0;
        end else begin
            state_q <= state_d;
            op_q    <= op_d;
            cnt_q   <= cnt_d;
        end
    end

    // Next-state and strobe decode; every output defaults to inactive
    always_comb begin
        state_d = state_q;
        op_d    = op_q;
        cnt_d   = cnt_q;
        c0      = 1'b0;
        c1      = 1'b0;
        c2      = 1'b0;
        c3      = 1'b0;
        c4      = 1'b0;
        c5      = 1'b0;
        c6      = 1'b0;
        c7      = 1'b0;
        done    = 1'b0;
        busy    = (state_q != IDLE) && (state_q != DONE);

        case (state_q)
            IDLE: begin
                if (start) begin
                    op_d    = op_e'(op);
                    state_d = (op_e'(op) == OP_RSVD) ? DONE : INIT;
                end
            end
            INIT: begin
                // Clear A and Q[-1]; operand X goes to Q (MUL) or M (ADD/SUB)
                c0    = 1'b1;
                cnt_d = '0;
                if (op_q == OP_MUL) begin
                    c1      = 1'b1;
                    state_d = LOADM;
                end else begin
                    c3      = 1'b1;
                    state_d = ADDX;
                end
            end
            ADDX: begin
                // A = 0 + M moves X into the accumulator
                c2      = 1'b1;
                state_d = LOADY;
            end
            LOADY: begin
                c3      = 1'b1;
                state_d = OP;
            end
            OP: begin
                c2      = 1'b1;
                c7      = (op_q == OP_SUB);
                state_d = OUT_A;
            end
            LOADM: begin
                c3      = 1'b1;
                state_d = TEST;
            end
            TEST: begin
                // Booth recoding: 01 adds M, 10 subtracts M, 00/11 do nothing
                case ({q0, q_m1})
                    2'b01: c2 = 1'b1;
                    2'b10: begin
                        c2 = 1'b1;
                        c7 = 1'b1;
                    end
                    default: ;
                endcase
                state_d = SHIFT;
            end
            SHIFT: begin
                c4      = 1'b1;
                cnt_d   = cnt_q + CNT_W'(1);
                state_d = (cnt_q == LAST_ITER) ? OUT_A : TEST;
            end
            OUT_A: begin
                c5      = 1'b1;
                state_d = (op_q == OP_MUL) ? OUT_Q : DONE;
            end
            OUT_Q: begin
                c6      = 1'b1;
                state_d = DONE;
            end
            DONE: begin
                done    = 1'b1;
                state_d = IDLE;
            end
            default: state_d = IDLE;
        endcase
    end

    assign cnt = cnt_q;

`ifdef ALU_CTRL_OVF_EN
    logic ovf_q;

    // Signed overflow captured on the add/sub; cleared when a new op starts
    always_ff @(posedge clk or negedge rst_b) begin
        if (!rst_b) begin
            ovf_q <= 1'b0;
        end else if (state_q == INIT) begin
            ovf_q <= 1'b0;
        end else if (state_q == OP) begin
            ovf_q <= (a_msb == (m_msb ^ c7)) && (sum_msb != a_msb);
        end
    end

    assign ovf = ovf_q;
`else
    logic unused_ovf_inputs;

    assign unused_ovf_inputs = a_msb ^ m_msb ^ sum_msb;
    assign ovf               = 1'b0;
`endif

endmodule

// File: tb/tb_alu_ctrl.sv
// Bench for alu_ctrl with a behavioural A/Q/M datapath driven by the strobes
// and an obus scoreboard fed with expected results at stimulus time.
module tb_alu_ctrl;
    import alu_pkg::*;

    logic       clk = 1'b0;
    logic       rst_b;
    logic       start;
    logic [1:0] op;
    logic       q0, q_m1, a_msb, m_msb, sum_msb;
    logic       c0, c1, c2, c3, c4, c5, c6, c7;
    logic       busy, done, ovf;
    logic [2:0] cnt;

    int checks   = 0;
    int failures = 0;

    // behavioural datapath
    logic [7:0] A_m = 8'h00, Q_m = 8'h00, M_m = 8'h00;
    logic       qm1_m = 1'b0;
    logic [7:0] inbus = 8'h00;
    logic [7:0] sum, obus;
    bit         forced = 1'b0;
    logic       fq0 = 1'b0, fqm1 = 1'b0;

    assign sum     = c7 ? (A_m - M_m) : (A_m + M_m);
    assign obus    = c5 ? A_m : (c6 ? Q_m : 8'h00);
    assign q0      = forced ? fq0 : Q_m[0];
    assign q_m1    = forced ? fqm1 : qm1_m;
    assign a_msb   = A_m[7];
    assign m_msb   = M_m[7];
    assign sum_msb = sum[7];

    alu_ctrl #(.N(8), .CNT_W(3)) dut (
        .clk(clk), .rst_b(rst_b), .start(start), .op(op),
        .q0(q0), .q_m1(q_m1), .a_msb(a_msb), .m_msb(m_msb), .sum_msb(sum_msb),
        .c0(c0), .c1(c1), .c2(c2), .c3(c3), .c4(c4), .c5(c5), .c6(c6), .c7(c7),
        .busy(busy), .done(done), .ovf(ovf), .cnt(cnt)
    );

    always #5 clk = ~clk;

    always @(posedge clk) begin
        if (c0) begin
            A_m   <= 8'h00;
            qm1_m <= 1'b0;
        end
        if (c1) Q_m <= inbus;
        if (c3) M_m <= inbus;
        if (c2) A_m <= sum;
        if (c4) begin
            A_m   <= {A_m[7], A_m[7:1]};
            Q_m   <= {A_m[0], Q_m[7:1]};
            qm1_m <= Q_m[0];
        end
    end

    // obus scoreboard
    logic [7:0] sb_q[$];
    bit         sb_en = 1'b0;

    always @(negedge clk) begin
        if (sb_en && rst_b && (c5 || c6)) begin
            checks++;
            if (sb_q.size() == 0) begin
                failures++;
                $display("FAIL sb_obus unexpected output obus=%h", obus);
            end else begin
                logic [7:0] e;
                e = sb_q.pop_front();
                if (obus !== e) begin
                    failures++;
                    $display("FAIL sb_obus got=%h exp=%h", obus, e);
                end
            end
        end
    end

    // per-cycle trace of one operation, index = cycles after accept edge
    logic [7:0] tr_strb[0:47];
    logic       tr_busy[0:47];
    logic [2:0] tr_cnt[0:47];
    logic [1:0] tr_qb[0:47];
    int         done_cyc;
    int         n_done;
    logic       ovf_at_done;

    task automatic exec_op(input logic [1:0] o, input logic [7:0] x, input logic [7:0] y,
                           input bit hold, input int ncyc);
        logic [1:0] pat[0:3];
        pat[0] = 2'b00; pat[1] = 2'b01; pat[2] = 2'b10; pat[3] = 2'b11;
        done_cyc    = -1;
        n_done      = 0;
        ovf_at_done = 1'b0;
        @(negedge clk);
        start = 1'b1;
        op    = o;
        @(posedge clk);
        #1;
        if (!hold) start = 1'b0;
        for (int k = 1; k <= ncyc; k++) begin
            if (k == 1) inbus = x;
            else if ((o == OP_MUL && k == 2) || (o != OP_MUL && k == 3)) inbus = y;
            else inbus = 8'h5A;
            if (forced && k >= 3) {fq0, fqm1} = pat[((k - 3) / 2) % 4];
            #1;
            tr_strb[k] = {c7, c6, c5, c4, c3, c2, c1, c0};
            tr_busy[k] = busy;
            tr_cnt[k]  = cnt;
            tr_qb[k]   = {q0, q_m1};
            if (done) begin
                n_done++;
                if (done_cyc < 0) begin
                    done_cyc    = k;
                    ovf_at_done = ovf;
                end
            end
            @(posedge clk);
            #1;
        end
    endtask

    task automatic test_reset();
        rst_b = 1'b0;
        start = 1'b0;
        op    = 2'b00;
        #1;
        checks++;
        if ({c7, c6, c5, c4, c3, c2, c1, c0} !== 8'h00) begin
            failures++; $display("FAIL reset_strobes got=%h exp=00", {c7, c6, c5, c4, c3, c2, c1, c0});
        end
        checks++;
        if (busy !== 1'b0) begin failures++; $display("FAIL reset_busy got=%b exp=0", busy); end
        checks++;
        if (done !== 1'b0) begin failures++; $display("FAIL reset_done got=%b exp=0", done); end
        checks++;
        if (ovf !== 1'b0) begin failures++; $display("FAIL reset_ovf got=%b exp=0", ovf); end
        checks++;
        if (cnt !== 3'd0) begin failures++; $display("FAIL reset_cnt got=%0d exp=0", cnt); end
        repeat (2) @(posedge clk);
        @(negedge clk);
        rst_b = 1'b1;
        repeat (2) @(posedge clk);
    endtask

    task automatic test_addsub(input logic [1:0] o, input logic [7:0] x, input logic [7:0] y,
                               input logic [7:0] res, input logic exp_ovf);
        logic [7:0] exp_tr[1:6];
        exp_tr[1] = 8'h09; exp_tr[2] = 8'h04; exp_tr[3] = 8'h08;
        exp_tr[4] = (o == OP_SUB) ? 8'h84 : 8'h04;
        exp_tr[5] = 8'h20; exp_tr[6] = 8'h00;
        sb_q.push_back(res);
        sb_en = 1'b1;
        exec_op(o, x, y, 1'b0, 8);
        sb_en = 1'b0;
        for (int k = 1; k <= 6; k++) begin
            checks++;
            if (tr_strb[k] !== exp_tr[k]) begin
                failures++; $display("FAIL addsub_strobe op=%0d cyc=%0d got=%h exp=%h", o, k, tr_strb[k], exp_tr[k]);
            end
        end
        checks++;
        if (done_cyc != 6) begin failures++; $display("FAIL addsub_latency got=%0d exp=6", done_cyc); end
        checks++;
        if (n_done != 1) begin failures++; $display("FAIL addsub_done_count got=%0d exp=1", n_done); end
        checks++;
        if (tr_busy[3] !== 1'b1 || tr_busy[6] !== 1'b0) begin
            failures++; $display("FAIL addsub_busy got=%b%b exp=10", tr_busy[3], tr_busy[6]);
        end
        checks++;
        if (ovf_at_done !== exp_ovf) begin
            failures++; $display("FAIL addsub_ovf got=%b exp=%b", ovf_at_done, exp_ovf);
        end
        checks++;
        if (sb_q.size() != 0) begin
            failures++; $display("FAIL addsub_sb_left got=%0d exp=0", sb_q.size()); sb_q.delete();
        end
    endtask

    task automatic test_mul();
        logic [7:0] e;
        sb_q.push_back(8'hFF);
        sb_q.push_back(8'hF1);
        sb_en = 1'b1;
        exec_op(OP_MUL, 8'hFD, 8'h05, 1'b0, 24);
        sb_en = 1'b0;
        checks++;
        if (tr_strb[1] !== 8'h03) begin failures++; $display("FAIL mul_init got=%h exp=03", tr_strb[1]); end
        checks++;
        if (tr_strb[2] !== 8'h08) begin failures++; $display("FAIL mul_loadm got=%h exp=08", tr_strb[2]); end
        for (int i = 0; i < 8; i++) begin
            case (tr_qb[3 + 2 * i])
                2'b01:   e = 8'h04;
                2'b10:   e = 8'h84;
                default: e = 8'h00;
            endcase
            checks++;
            if (tr_strb[3 + 2 * i] !== e) begin
                failures++; $display("FAIL mul_test pair=%0d got=%h exp=%h", i, tr_strb[3 + 2 * i], e);
            end
            checks++;
            if (tr_strb[4 + 2 * i] !== 8'h10) begin
                failures++; $display("FAIL mul_shift pair=%0d got=%h exp=10", i, tr_strb[4 + 2 * i]);
            end
            checks++;
            if (tr_cnt[3 + 2 * i] !== 3'(i)) begin
                failures++; $display("FAIL mul_cnt pair=%0d got=%0d exp=%0d", i, tr_cnt[3 + 2 * i], i);
            end
        end
        for (int k = 1; k <= 24; k++) begin
            if (tr_strb[k][2] && tr_strb[k][4]) begin
                checks++; failures++; $display("FAIL mul_c2_c4 cyc=%0d got=%h exp=not_both", k, tr_strb[k]);
            end
        end
        checks++;
        if (tr_strb[19] !== 8'h20 || tr_strb[20] !== 8'h40) begin
            failures++; $display("FAIL mul_out got=%h,%h exp=20,40", tr_strb[19], tr_strb[20]);
        end
        checks++;
        if (done_cyc != 21) begin failures++; $display("FAIL mul_latency got=%0d exp=21", done_cyc); end
        checks++;
        if (sb_q.size() != 0) begin
            failures++; $display("FAIL mul_sb_left got=%0d exp=0", sb_q.size()); sb_q.delete();
        end
    endtask

    task automatic test_test_decode();
        logic [7:0] exp_dec[0:3];
        exp_dec[0] = 8'h00; exp_dec[1] = 8'h04; exp_dec[2] = 8'h84; exp_dec[3] = 8'h00;
        forced = 1'b1;
        exec_op(OP_MUL, 8'h11, 8'h22, 1'b0, 24);
        forced = 1'b0;
        for (int i = 0; i < 8; i++) begin
            checks++;
            if (tr_strb[3 + 2 * i] !== exp_dec[i % 4]) begin
                failures++; $display("FAIL decode pair=%0d got=%h exp=%h", i, tr_strb[3 + 2 * i], exp_dec[i % 4]);
            end
        end
        checks++;
        if (done_cyc != 21) begin failures++; $display("FAIL decode_latency got=%0d exp=21", done_cyc); end
    endtask

    task automatic test_rsvd_and_hold();
        int waited;
        exec_op(OP_RSVD, 8'h00, 8'h00, 1'b0, 3);
        checks++;
        if (tr_strb[1] !== 8'h00) begin failures++; $display("FAIL rsvd_strobes got=%h exp=00", tr_strb[1]); end
        checks++;
        if (done_cyc != 1) begin failures++; $display("FAIL rsvd_latency got=%0d exp=1", done_cyc); end
        checks++;
        if (tr_busy[1] !== 1'b0) begin failures++; $display("FAIL rsvd_busy got=%b exp=0", tr_busy[1]); end
        // start held high for the whole MUL, including its DONE cycle
        exec_op(OP_MUL, 8'h03, 8'h04, 1'b1, 23);
        start = 1'b0;
        checks++;
        if (done_cyc != 21 || n_done != 1) begin
            failures++; $display("FAIL hold_done got=cyc%0d/n%0d exp=cyc21/n1", done_cyc, n_done);
        end
        checks++;
        if (tr_strb[22] !== 8'h00 || tr_busy[22] !== 1'b0) begin
            failures++; $display("FAIL hold_idle got=%h/%b exp=00/0", tr_strb[22], tr_busy[22]);
        end
        checks++;
        if (tr_strb[23] !== 8'h03) begin failures++; $display("FAIL hold_reaccept got=%h exp=03", tr_strb[23]); end
        waited = 0;
        while (!done && waited < 40) begin
            @(posedge clk);
            #1;
            waited++;
        end
        checks++;
        if (!done) begin failures++; $display("FAIL hold_second_done got=timeout exp=done"); end
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset_mid_mul();
        int seen_done, seen_busy;
        @(negedge clk);
        start = 1'b1;
        op    = OP_MUL;
        @(posedge clk);
        #1;
        start = 1'b0;
        repeat (8) begin
            @(posedge clk);
            #1;
        end
        checks++;
        if (busy !== 1'b1 || cnt !== 3'd3) begin
            failures++; $display("FAIL midmul_pre got=busy%b/cnt%0d exp=busy1/cnt3", busy, cnt);
        end
        rst_b = 1'b0;
        #1;
        checks++;
        if ({c7, c6, c5, c4, c3, c2, c1, c0} !== 8'h00) begin
            failures++; $display("FAIL midmul_strobes got=%h exp=00", {c7, c6, c5, c4, c3, c2, c1, c0});
        end
        checks++;
        if (busy !== 1'b0) begin failures++; $display("FAIL midmul_busy got=%b exp=0", busy); end
        checks++;
        if (cnt !== 3'd0) begin failures++; $display("FAIL midmul_cnt got=%0d exp=0", cnt); end
        seen_done = 0;
        seen_busy = 0;
        repeat (2) begin
            @(posedge clk);
            #1;
            if (done) seen_done++;
        end
        @(negedge clk);
        rst_b = 1'b1;
        repeat (30) begin
            @(posedge clk);
            #1;
            if (done) seen_done++;
            if (busy || c0 || c4) seen_busy++;
        end
        checks++;
        if (seen_done != 0) begin failures++; $display("FAIL midmul_done got=%0d exp=0", seen_done); end
        checks++;
        if (seen_busy != 0) begin failures++; $display("FAIL midmul_activity got=%0d exp=0", seen_busy); end
    endtask

    initial begin
        #300000;
        $display("FAIL watchdog got=timeout exp=finish");
        $fatal(1, "watchdog expired");
    end

    initial begin
        test_reset();
        test_addsub(OP_ADD, 8'h25, 8'h13, 8'h38, 1'b0);
`ifdef ALU_CTRL_OVF_EN
        test_addsub(OP_SUB, 8'h80, 8'h01, 8'h7F, 1'b1);
`else
        test_addsub(OP_SUB, 8'h80, 8'h01, 8'h7F, 1'b0);
`endif
        test_mul();
        test_test_decode();
        test_rsvd_and_hold();
        test_reset_mid_mul();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
